// File: rtl/ddr2_req_queue_if.sv
// ddr2_req_queue_if: user request/response port and controller c_* bus of the DDR2 request queue
// slave  : the queue side (accepts u_* requests, drives c_* requests and r_* responses)
// master : the environment side (user logic plus the DDR2 controller)
interface ddr2_req_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 26,
    parameter int DATA_W = 64
);
    logic                     u_valid;
    logic                     u_ready;
    logic                     u_we;
    logic [ADDR_W-1:0]        u_addr;
    logic [DATA_W-1:0]        u_wdata;
    logic                     r_valid;
    logic [DATA_W-1:0]        r_data;
    logic [$clog2(DEPTH):0]   count;
    logic                     busy;
    logic [ADDR_W-1:0]        c_addr;
    logic [DATA_W-1:0]        c_data_in;
    logic                     c_rd_req;
    logic                     c_wr_req;
    logic                     c_rdy;
    logic                     c_ack;
    logic [DATA_W-1:0]        c_data_out;

    modport slave (
        input  u_valid, u_we, u_addr, u_wdata, c_rdy, c_ack, c_data_out,
        output u_ready, r_valid, r_data, count, busy, c_addr, c_data_in, c_rd_req, c_wr_req
    );

    modport master (
        output u_valid, u_we, u_addr, u_wdata, c_rdy, c_ack, c_data_out,
        input  u_ready, r_valid, r_data, count, busy, c_addr, c_data_in, c_rd_req, c_wr_req
    );
endinterface

// File: rtl/ddr2_req_queue.sv
// ddr2_req_queue: in-order request FIFO feeding one DDR2 controller transaction at a time
// clk, rst : system clock, asynchronous active-high reset
// bus      : u_valid/u_ready/u_we/u_addr/u_wdata request port, r_valid/r_data read return,
//            count/busy status, c_addr/c_data_in/c_rd_req/c_wr_req/c_rdy/c_ack/c_data_out controller bus
module ddr2_req_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 26,
    parameter int DATA_W = 64
) (
    input  logic clk,
    input  logic rst,
    ddr2_req_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {Q_IDLE, Q_REQ, Q_HOLD} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count_n;
    logic              we_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              push, pop;
    logic [ADDR_W-1:0] c_addr_n;
    logic [DATA_W-1:0] c_data_in_n, r_data_n;
    logic              c_rd_req_n, c_wr_req_n, r_valid_n;

    assign push    = bus.u_valid && bus.u_ready;
    assign count_n = bus.count + CW'(push) - CW'(pop);

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        c_addr_n    = bus.c_addr;
        c_data_in_n = bus.c_data_in;
        c_rd_req_n  = bus.c_rd_req;
        c_wr_req_n  = bus.c_wr_req;
        r_valid_n   = 1'b0;
        r_data_n    = bus.r_data;
        case (state)
            Q_IDLE: if (bus.count != '0 && bus.c_rdy) begin
                c_addr_n    = addr_mem[rptr];
                c_data_in_n = data_mem[rptr];
                c_wr_req_n  = we_mem[rptr];
                c_rd_req_n  = !we_mem[rptr];
                state_n     = Q_REQ;
            end
            Q_REQ: if (bus.c_ack) begin
                c_rd_req_n = 1'b0;
                c_wr_req_n = 1'b0;
                r_valid_n  = bus.c_rd_req;
                r_data_n   = bus.c_rd_req ? bus.c_data_out : bus.r_data;
                state_n    = Q_HOLD;
            end
            // The entry stays at the head (and c_addr/c_data_in stay put) until the
            // controller is idle again, since it samples write data after acking.
            Q_HOLD: if (bus.c_rdy) begin
                pop     = 1'b1;
                state_n = Q_IDLE;
            end
            default: state_n = Q_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= Q_IDLE;
            wptr          <= '0;
            rptr          <= '0;
            bus.count     <= '0;
            bus.u_ready   <= 1'b1;
            bus.busy      <= 1'b0;
            bus.c_addr    <= '0;
            bus.c_data_in <= '0;
            bus.c_rd_req  <= 1'b0;
            bus.c_wr_req  <= 1'b0;
            bus.r_valid   <= 1'b0;
            bus.r_data    <= '0;
        end else begin
            state         <= state_n;
            wptr          <= wptr + PW'(push);
            rptr          <= rptr + PW'(pop);
            bus.count     <= count_n;
            bus.u_ready   <= count_n != CW'(DEPTH);
            bus.busy      <= (count_n != '0) || (state_n != Q_IDLE);
            bus.c_addr    <= c_addr_n;
            bus.c_data_in <= c_data_in_n;
            bus.c_rd_req  <= c_rd_req_n;
            bus.c_wr_req  <= c_wr_req_n;
            bus.r_valid   <= r_valid_n;
            bus.r_data    <= r_data_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            we_mem[wptr]   <= bus.u_we;
            addr_mem[wptr] <= bus.u_addr;
            data_mem[wptr] <= bus.u_wdata;
        end
    end
endmodule

// File: tb/tb_ddr2_req_queue.sv
// tb_ddr2_req_queue: directed bench for ddr2_req_queue with a transaction-level reference model
module tb_ddr2_req_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        we;
        logic [25:0] addr;
        logic [63:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ddr2_req_queue_if #(.DEPTH(DEPTH), .ADDR_W(26), .DATA_W(64)) bif ();
    ddr2_req_queue #(.DEPTH(DEPTH), .ADDR_W(26), .DATA_W(64)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    req_t        mq[$];
    req_t        nr;
    bit          m_issued, m_acked, m_rvalid, can_push;
    logic [25:0] m_addr;
    logic [63:0] m_din, m_rdata;
    logic        e_rd, e_wr;

    // Model: the head request is "issued" once the controller is idle, "acked" on c_ack,
    // and leaves the queue once the controller is idle again.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_issued = 0;
            m_acked  = 0;
            m_rvalid = 0;
            m_addr   = '0;
            m_din    = '0;
            m_rdata  = '0;
        end else begin
            can_push = bif.u_valid && mq.size() < DEPTH;
            nr       = '{bif.u_we, bif.u_addr, bif.u_wdata};
            m_rvalid = 0;
            if (!m_issued) begin
                if (mq.size() > 0 && bif.c_rdy) begin
                    m_issued = 1;
                    m_addr   = mq[0].addr;
                    m_din    = mq[0].data;
                end
            end else if (!m_acked) begin
                if (bif.c_ack) begin
                    m_acked = 1;
                    if (!mq[0].we) begin
                        m_rvalid = 1;
                        m_rdata  = bif.c_data_out;
                    end
                end
            end else if (bif.c_rdy) begin
                void'(mq.pop_front());
                m_issued = 0;
                m_acked  = 0;
            end
            if (can_push) mq.push_back(nr);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            e_rd = m_issued && !m_acked && mq.size() > 0 && !mq[0].we;
            e_wr = m_issued && !m_acked && mq.size() > 0 && mq[0].we;
            chk("m_count", 64'(bif.count), 64'(mq.size()));
            chk("m_u_ready", 64'(bif.u_ready), 64'(mq.size() < DEPTH));
            chk("m_busy", 64'(bif.busy), 64'(mq.size() != 0 || m_issued));
            chk("m_c_rd_req", 64'(bif.c_rd_req), 64'(e_rd));
            chk("m_c_wr_req", 64'(bif.c_wr_req), 64'(e_wr));
            chk("m_c_addr", 64'(bif.c_addr), 64'(m_addr));
            chk("m_c_data_in", bif.c_data_in, m_din);
            chk("m_r_valid", 64'(bif.r_valid), 64'(m_rvalid));
            chk("m_r_data", bif.r_data, m_rdata);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic we, input logic [25:0] addr, input logic [63:0] data);
        bif.u_valid = 1'b1;
        bif.u_we    = we;
        bif.u_addr  = addr;
        bif.u_wdata = data;
        tick();
        bif.u_valid = 1'b0;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!(bif.c_rd_req || bif.c_wr_req) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (!(bif.c_rd_req || bif.c_wr_req)) begin
            errors++;
            $display("FAIL wait_req: no request after %0d cycles", max);
        end
    endtask

    task automatic serve(input logic [25:0] exp_addr, input logic [63:0] rdata);
        wait_req(20);
        chk("order_addr", 64'(bif.c_addr), 64'(exp_addr));
        bif.c_ack      = 1'b1;
        bif.c_data_out = rdata;
        tick();
        bif.c_ack = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif.u_valid    = 1'b0;
        bif.u_we       = 1'b0;
        bif.u_addr     = '0;
        bif.u_wdata    = '0;
        bif.c_rdy      = 1'b0;
        bif.c_ack      = 1'b0;
        bif.c_data_out = '0;
        tick();
        tick();
        chk("rst_u_ready", 64'(bif.u_ready), 64'd1);
        chk("rst_count", 64'(bif.count), 64'd0);
        chk("rst_busy", 64'(bif.busy), 64'd0);
        chk("rst_c_rd_req", 64'(bif.c_rd_req), 64'd0);
        #2 rst = 1'b0;
        tick();

        // single read
        bif.c_rdy = 1'b1;
        push(1'b0, 26'h0001234, 64'h0);
        chk("rd_count1", 64'(bif.count), 64'd1);
        wait_req(5);
        chk("rd_req", 64'(bif.c_rd_req), 64'd1);
        chk("rd_addr", 64'(bif.c_addr), 64'h0001234);
        for (int i = 0; i < 7; i++) tick();
        chk("rd_req_held", 64'(bif.c_rd_req), 64'd1);
        bif.c_ack      = 1'b1;
        bif.c_data_out = 64'hDEADBEEF_CAFEF00D;
        tick();
        bif.c_ack = 1'b0;
        chk("rd_r_valid", 64'(bif.r_valid), 64'd1);
        chk("rd_r_data", bif.r_data, 64'hDEADBEEF_CAFEF00D);
        chk("rd_req_drop", 64'(bif.c_rd_req), 64'd0);
        tick();
        chk("rd_r_valid_once", 64'(bif.r_valid), 64'd0);
        chk("rd_count0", 64'(bif.count), 64'd0);

        // write data hold
        push(1'b1, 26'h2000, 64'h0123456789ABCDEF);
        wait_req(5);
        chk("wr_req", 64'(bif.c_wr_req), 64'd1);
        bif.c_rdy = 1'b0;
        tick();
        tick();
        bif.c_ack = 1'b1;
        tick();
        bif.c_ack = 1'b0;
        chk("wr_req_drop", 64'(bif.c_wr_req), 64'd0);
        for (int i = 0; i < 9; i++) begin
            chk("wr_hold_data", bif.c_data_in, 64'h0123456789ABCDEF);
            chk("wr_no_rvalid", 64'(bif.r_valid), 64'd0);
            tick();
        end
        bif.c_rdy = 1'b1;
        tick();
        chk("wr_count0", 64'(bif.count), 64'd0);

        // fill and backpressure
        bif.c_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bif.u_valid = 1'b1;
            bif.u_we    = i[0];
            bif.u_addr  = 26'h100 + 26'(i);
            bif.u_wdata = 64'h1111 * 64'(i + 1);
            tick();
        end
        bif.u_valid = 1'b0;
        chk("fill_count", 64'(bif.count), 64'd4);
        chk("fill_u_ready", 64'(bif.u_ready), 64'd0);
        bif.c_rdy = 1'b1;
        for (int i = 0; i < 4; i++) serve(26'h100 + 26'(i), 64'hA0 + 64'(i));
        chk("fill_drained", 64'(bif.count), 64'd0);

        // simultaneous push and pop
        bif.c_rdy = 1'b0;
        push(1'b0, 26'h300, 64'h0);
        push(1'b1, 26'h301, 64'h55);
        bif.c_rdy = 1'b1;
        wait_req(5);
        bif.c_rdy      = 1'b0;
        bif.c_ack      = 1'b1;
        bif.c_data_out = 64'hBEEF;
        tick();
        bif.c_ack = 1'b0;
        chk("pp_count_before", 64'(bif.count), 64'd2);
        bif.c_rdy = 1'b1;
        push(1'b0, 26'h302, 64'h0);
        chk("pp_count_same", 64'(bif.count), 64'd2);
        serve(26'h301, 64'h0);
        serve(26'h302, 64'h77);
        chk("pp_last_rdata", bif.r_data, 64'h77);

        // controller busy
        bif.c_rdy = 1'b0;
        push(1'b0, 26'h400, 64'h0);
        for (int i = 0; i < 50; i++) begin
            if (bif.c_rd_req) chk("busy_no_req", 64'(bif.c_rd_req), 64'd0);
            tick();
        end
        chk("busy_count", 64'(bif.count), 64'd1);
        bif.c_rdy = 1'b1;
        serve(26'h400, 64'h99);

        // reset mid-operation
        bif.c_rdy = 1'b0;
        push(1'b0, 26'h500, 64'h0);
        push(1'b1, 26'h501, 64'h1);
        push(1'b0, 26'h502, 64'h0);
        bif.c_rdy = 1'b1;
        wait_req(5);
        bif.c_rdy = 1'b0;
        chk("mid_count3", 64'(bif.count), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rd_req", 64'(bif.c_rd_req), 64'd0);
        chk("mid_wr_req", 64'(bif.c_wr_req), 64'd0);
        chk("mid_r_valid", 64'(bif.r_valid), 64'd0);
        chk("mid_count", 64'(bif.count), 64'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        bif.c_ack      = 1'b1;
        bif.c_data_out = 64'hBAD;
        tick();
        bif.c_ack = 1'b0;
        chk("late_ack_r_valid", 64'(bif.r_valid), 64'd0);
        bif.c_rdy = 1'b1;
        tick();
        tick();
        chk("late_ack_busy", 64'(bif.busy), 64'd0);
        chk("late_ack_rd_req", 64'(bif.c_rd_req), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
